debouncer: RTL and testbench
============================

// Module: debouncer
// PURPOSE
//  Debounces one already-synchronized mechanical input (button/switch on Arty A7).
//  Emits a filtered level plus one-cycle rise/fall event pulses.
//  Sits directly downstream of a synchronizer stage; signal_in must already be in clk_in's domain.
//  Consumers: GPIO/interrupt logic on the Wishbone side.
// PARAMETERS
//  STABLE_CYCLES  1_000_000  consecutive equal samples needed to accept a new level (10 ms @100 MHz); legal >= 1
//  CNT_W          localparam = $clog2(STABLE_CYCLES+1); width of the stability counter
// PORTS
//  clk_in      in   1  system clock; every register samples on posedge
//  reset_n_in  in   1  asynchronous reset, active-low; assertion is immediate
//  signal_in   in   1  synchronized raw input, may bounce
//  level_out   out  1  debounced level, registered
//  rise_out    out  1  one-cycle pulse on accepted 0->1 transition, registered
//  fall_out    out  1  one-cycle pulse on accepted 1->0 transition, registered
// BEHAVIOUR
//  Reset (reset_n_in=0, async)
//   - state=LOW, cnt=0, level_out=0, rise_out=0, fall_out=0.
//   - No pulse is generated on reset release, even if signal_in=1.
//  FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT. cnt counts consecutive samples of the candidate level.
//  LOW
//   - signal_in=1: if STABLE_CYCLES==1, go to HIGH; else go to RISE_WAIT with cnt=1.
//   - Otherwise remain in LOW.
//  RISE_WAIT
//   - signal_in=0 (bounce): go to LOW, cnt=0; no pulse.
//   - signal_in=1 and cnt==STABLE_CYCLES-1: go to HIGH, cnt=0.
//   - Otherwise cnt++.
//  HIGH, FALL_WAIT: mirror of LOW, RISE_WAIT with signal_in inverted.
//  Outputs
//   - On entry to HIGH: level_out<=1 and rise_out<=1 on the same edge.
//   - On entry to LOW from FALL_WAIT: level_out<=0 and fall_out<=1 on the same edge.
//   - rise_out/fall_out are 1 for exactly one cycle.
//   - rise_out and fall_out are never high together.
//   - level_out toggles only together with a pulse.
//  Latency
//   - level_out changes on the edge that takes the STABLE_CYCLES-th consecutive opposite sample.
//   - Counting starts at the first opposite sample.
//   - For STABLE_CYCLES=1: output follows signal_in with 1 cycle of delay.
//  Boundaries
//   - Any contrary sample during a WAIT state restarts qualification from zero.
//   - cnt never exceeds STABLE_CYCLES-1, so it cannot wrap.
//   - cnt is held at 0 in LOW and HIGH.
//   - Reset mid-WAIT aborts the pending transition; after release, qualification restarts from LOW.
//   - A toggle of signal_in on the same edge a transition completes is treated as the first sample in the new state.
// STRUCTURE
//  Package debounce_pkg holds:
//   - typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} debounce_state_t
//   - DEBOUNCE_DEFAULT_CYCLES = 1_000_000
//  Single module, no sub-modules; one always_ff with async reset (state, cnt, outputs) plus one always_comb next-state.
//  Top-level wiring: pad -> synchronizer -> debouncer; multi-bit inputs use one instance per bit.
// TESTING (bench uses STABLE_CYCLES=4 unless noted)
//  1. Clean step: signal_in 0->1 held 10 cycles
//     -> level_out=1 and rise_out pulse on the 4th high-sample edge; fall_out stays 0.
//  2. Bounce: pattern 1,1,0,1,1,1,0 then hold 1
//     -> no pulse until 4 consecutive 1s after the last 0; exactly one rise_out.
//  3. Release: from HIGH, hold signal_in=0 for 4 cycles
//     -> fall_out one-cycle pulse and level_out=0 on the 4th edge; 3-cycle low glitch -> no change.
//  4. Reset mid-wait: 2 high samples in RISE_WAIT, assert reset_n_in
//     -> outputs 0 immediately; release with input still 1 -> rise after 4 further samples, no pulse at release.
//  5. STABLE_CYCLES=1: toggle signal_in every cycle
//     -> level_out tracks with 1-cycle delay; alternating rise/fall pulses.
//  6. Pulse property checks: assertions that rise_out & fall_out never overlap, pulses last 1 cycle, cnt < STABLE_CYCLES.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the debouncer
//
// Purpose : FSM state encoding and the default qualification length.
// Ports   : none (package).

package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } debounce_state_t;

    // 10 ms at 100 MHz.
    localparam int DEBOUNCE_DEFAULT_CYCLES = 1_000_000;

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - single-input debouncer with level output and edge pulses
//
// Purpose : Accepts a new level on signal_in only after STABLE_CYCLES
//           consecutive equal samples, then emits the filtered level and a
//           one-cycle rise/fall pulse on the same edge.
// Ports   :
//   clk_in      in   1  system clock, posedge
//   reset_n_in  in   1  asynchronous active-low reset
//   signal_in   in   1  already-synchronized raw input, may bounce
//   level_out   out  1  debounced level, registered
//   rise_out    out  1  one-cycle pulse on an accepted 0->1 transition
//   fall_out    out  1  one-cycle pulse on an accepted 1->0 transition

module debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic signal_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    // With a one-sample window the WAIT states are never used.
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    debounce_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= LOW;
            cnt       <= CNT_ZERO;
            level_out <= 1'b0;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            rise_out  <= rise_nxt;
            fall_out  <= fall_nxt;
        end
    end

    // cnt holds the number of consecutive candidate samples already taken;
    // the sample that would make it STABLE_CYCLES completes the transition
    // instead of being stored, so cnt stays below STABLE_CYCLES.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = CNT_ZERO;
        level_nxt = level_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        unique case (state)
            LOW: begin
                if (signal_in) begin
                    if (SINGLE) begin
                        state_nxt = HIGH;
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = RISE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end

            RISE_WAIT: begin
                if (!signal_in) begin
                    state_nxt = LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            HIGH: begin
                if (!signal_in) begin
                    if (SINGLE) begin
                        state_nxt = LOW;
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = FALL_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end

            FALL_WAIT: begin
                if (signal_in) begin
                    state_nxt = HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = LOW;
            end
        endcase
    end

    a_cnt_bound: assert property (@(posedge clk_in) disable iff (!reset_n_in)
        cnt < CNT_W'(STABLE_CYCLES));

    a_no_overlap: assert property (@(posedge clk_in) disable iff (!reset_n_in)
        !(rise_out && fall_out));

    a_rise_one_cycle: assert property (@(posedge clk_in) disable iff (!reset_n_in)
        rise_out |=> !rise_out);

    a_fall_one_cycle: assert property (@(posedge clk_in) disable iff (!reset_n_in)
        fall_out |=> !fall_out);

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - self-checking bench for debouncer (windows of 4 and 1)

module tb_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic sig;
    logic lvl4, rise4, fall4;
    logic lvl1, rise1, fall1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    debouncer #(.STABLE_CYCLES(4)) dut4 (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .signal_in  (sig),
        .level_out  (lvl4),
        .rise_out   (rise4),
        .fall_out   (fall4)
    );

    debouncer #(.STABLE_CYCLES(1)) dut1 (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .signal_in  (sig),
        .level_out  (lvl1),
        .rise_out   (rise1),
        .fall_out   (fall1)
    );

    // Reference: an accepted level flips once N consecutive samples have
    // disagreed with it; the run restarts after every flip and after reset.
    int m_n[2] = '{4, 1};
    bit m_lvl[2];
    int m_run[2];
    bit m_rise[2];
    bit m_fall[2];
    bit prev_rise[2];
    bit prev_fall[2];

    typedef struct {
        logic s;
        logic lvl;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 1'b0;
            m_run[k] = 0;
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            prev_rise[k] = 1'b0;
            prev_fall[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit s);
        for (int k = 0; k < 2; k++) begin
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (s != m_lvl[k]) m_run[k]++;
            else m_run[k] = 0;
            if (m_run[k] == m_n[k]) begin
                m_lvl[k] = ~m_lvl[k];
                m_rise[k] = m_lvl[k];
                m_fall[k] = ~m_lvl[k];
                m_run[k] = 0;
            end
        end
    endtask

    // Drive one sample, clock it in, advance the model and check.
    // use_model4 selects whether dut4 is compared against the model here
    // (table vectors compare dut4 against their own expectations instead).
    task automatic step(input bit s, input bit use_model4);
        sig = s;
        @(posedge clk);
        #1;
        model_step(s);
        check("n1_level", lvl1, m_lvl[1]);
        check("n1_rise", rise1, m_rise[1]);
        check("n1_fall", fall1, m_fall[1]);
        if (use_model4) begin
            check("n4_level", lvl4, m_lvl[0]);
            check("n4_rise", rise4, m_rise[0]);
            check("n4_fall", fall4, m_fall[0]);
        end
        check("n4_no_overlap", rise4 & fall4, 0);
        check("n4_rise_width", rise4 & prev_rise[0], 0);
        check("n4_fall_width", fall4 & prev_fall[0], 0);
        prev_rise[0] = rise4;
        prev_fall[0] = fall4;
    endtask

    task automatic add(input logic s, input logic l, input logic r, input logic f, input int reps);
        vec_t v;
        v.s = s; v.lvl = l; v.rise = r; v.fall = f;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    // Assert reset between edges, check outputs clear at once, release
    // one clock later away from the edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_level4", lvl4, 0);
        check("rst_async_rise4", rise4, 0);
        check("rst_async_fall4", fall4, 0);
        check("rst_async_level1", lvl1, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_rise4", rise4, 0);
        check("rst_release_level4", lvl4, 0);
    endtask

    initial begin
        bit cur;
        int hold;

        rst_n = 1'b0;
        sig = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_level4", lvl4, 0);
        check("reset_rise4", rise4, 0);
        check("reset_fall4", fall4, 0);
        check("reset_level1", lvl1, 0);
        check("reset_rise1", rise1, 0);
        check("reset_fall1", fall1, 0);
        rst_n = 1'b1;

        // Clean step, then glitch / release, then bouncing press.
        add(0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 3);
        add(1, 1, 1, 0, 1);
        add(1, 1, 0, 0, 6);
        add(0, 1, 0, 0, 3);
        add(1, 1, 0, 0, 1);
        add(0, 1, 0, 0, 3);
        add(0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 3);
        add(1, 1, 1, 0, 1);
        add(1, 1, 0, 0, 2);

        foreach (vecs[i]) begin
            step(vecs[i].s, 1'b0);
            check($sformatf("vec%0d_level", i), lvl4, vecs[i].lvl);
            check($sformatf("vec%0d_rise", i), rise4, vecs[i].rise);
            check($sformatf("vec%0d_fall", i), fall4, vecs[i].fall);
        end

        // Reset during FALL_WAIT from HIGH: level must drop immediately.
        step(0, 1'b1);
        step(0, 1'b1);
        check("t4_level_before_rst", lvl4, 1);
        sig = 1'b1;
        pulse_reset();

        // Two high samples into RISE_WAIT, then reset with input held high.
        step(1, 1'b1);
        step(1, 1'b1);
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1, 1'b1);
            check($sformatf("t4_rise_at_%0d", i), rise4, (i == 4) ? 1 : 0);
        end

        // One-sample window: toggle every cycle.
        cur = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = ~cur;
            step(cur, 1'b1);
            check("t5_level_follow", lvl1, cur);
        end

        // Randomized bursts of mixed lengths around the window size.
        cur = 1'b0;
        for (int i = 0; i < 150; i++) begin
            cur = ~cur;
            hold = $urandom_range(1, 6);
            for (int j = 0; j < hold; j++) step(cur, 1'b1);
            if ($urandom_range(0, 40) == 0) begin
                pulse_reset();
                prev_rise[0] = 1'b0;
                prev_fall[0] = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
